// File: rtl/lcd_bus_seq_if.sv
// lcd_bus_seq_if: CPU request/response handshake and 8080-style LCD pins.
// slave = sequencer side, master = register block / pad side.
interface lcd_bus_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rs;
    logic        req_we;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;
    logic        lcd_nrst;
    logic        lcd_csel;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic [15:0] lcd_data_o;
    logic [15:0] lcd_data_i;
    logic [15:0] lcd_data_z;

    modport slave (
        input  req_valid, req_rs, req_we, req_wdata, lcd_data_i,
        output req_ready, rsp_valid, rsp_rdata, busy,
        output lcd_nrst, lcd_csel, lcd_rs, lcd_wr, lcd_rd,
        output lcd_data_o, lcd_data_z
    );

    modport master (
        output req_valid, req_rs, req_we, req_wdata, lcd_data_i,
        input  req_ready, rsp_valid, rsp_rdata, busy,
        input  lcd_nrst, lcd_csel, lcd_rs, lcd_wr, lcd_rd,
        input  lcd_data_o, lcd_data_z
    );
endinterface

// File: rtl/lcd_bus_seq.sv
// lcd_bus_seq: 8080-style 16-bit LCD bus sequencer with panel reset pulse.
// Read path enabled by defining LCD_BUS_SEQ_READ_EN.
module lcd_bus_seq #(
    parameter int SETUP_CYC    = 2,
    parameter int STROBE_CYC   = 4,
    parameter int HOLD_CYC     = 2,
    parameter int RST_CYC      = 16,
    parameter int RST_WAIT_CYC = 32
) (
    input logic         clk,
    input logic         resetn,
    lcd_bus_seq_if.slave bus
);
    localparam int M1 = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int M2 = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
    localparam int M3 = (M1 > M2) ? M1 : M2;
    localparam int MX = (M3 > RST_WAIT_CYC) ? M3 : RST_WAIT_CYC;
    localparam int CW = $clog2(MX) + 1;

    localparam logic [CW-1:0] L_SETUP  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] L_STROBE = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] L_HOLD   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] L_RST    = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] L_WAIT   = CW'(RST_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        RST_LOW, RST_WAIT, IDLE, SETUP, STROBE, HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic          we_q, we_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          expired;
    logic          active_d;

    logic          nrst_q, nrst_d;
    logic          csel_q, csel_d;
    logic          lrs_q, lrs_d;
    logic          wr_q, wr_d;
    logic          z_q, z_d;
    logic [15:0]   dout_q, dout_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    assign expired = (cnt_q == '0);

    // Next state, counter reload and request latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 1'b1;
        rs_d    = rs_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        unique case (state_q)
            RST_LOW: begin
                if (expired) begin
                    state_d = RST_WAIT;
                    cnt_d   = L_WAIT;
                end
            end
            RST_WAIT: begin
                if (expired) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (bus.req_valid && ready_q) begin
                    rs_d    = bus.req_rs;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
`ifdef LCD_BUS_SEQ_READ_EN
                    state_d = SETUP;
                    cnt_d   = L_SETUP;
`else
                    if (bus.req_we) begin
                        state_d = SETUP;
                        cnt_d   = L_SETUP;
                    end
`endif
                end
            end
            SETUP: begin
                if (expired) begin
                    state_d = STROBE;
                    cnt_d   = L_STROBE;
                end
            end
            STROBE: begin
                if (expired) begin
                    state_d = HOLD;
                    cnt_d   = L_HOLD;
                end
            end
            HOLD: begin
                if (expired) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RST_LOW;
                cnt_d   = L_RST;
            end
        endcase
    end

    // Registered outputs are derived from the state being entered.
    always_comb begin
        active_d = (state_d == SETUP) || (state_d == STROBE) ||
                   (state_d == HOLD);
        nrst_d   = (state_d != RST_LOW);
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
        csel_d   = !active_d;
        lrs_d    = active_d ? rs_d : lrs_q;
        wr_d     = !((state_d == STROBE) && we_d);
        z_d      = !(active_d && we_d);
        dout_d   = (active_d && we_d) ? wdata_d : dout_q;
    end

    // State, counter and latched request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RST_LOW;
            cnt_q   <= L_RST;
            rs_q    <= 1'b1;
            we_q    <= 1'b1;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // Pin and handshake output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            nrst_q  <= 1'b0;
            csel_q  <= 1'b1;
            lrs_q   <= 1'b1;
            wr_q    <= 1'b1;
            z_q     <= 1'b1;
            dout_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            nrst_q  <= nrst_d;
            csel_q  <= csel_d;
            lrs_q   <= lrs_d;
            wr_q    <= wr_d;
            z_q     <= z_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

`ifdef LCD_BUS_SEQ_READ_EN
    logic        rd_q, rd_d;
    logic        rspv_q, rspv_d;
    logic [15:0] rdata_q, rdata_d;

    // Read strobe, capture on the last strobe cycle, pulse on IDLE entry.
    always_comb begin
        rd_d    = !((state_d == STROBE) && !we_d);
        rspv_d  = (state_q == HOLD) && (state_d == IDLE) && !we_q;
        rdata_d = rdata_q;
        if ((state_q == STROBE) && expired && !we_q)
            rdata_d = bus.lcd_data_i;
    end

    // Read-path registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_q    <= 1'b1;
            rspv_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            rd_q    <= rd_d;
            rspv_q  <= rspv_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.lcd_rd    = rd_q;
    assign bus.rsp_valid = rspv_q;
    assign bus.rsp_rdata = rdata_q;
`else
    logic unused_rdata;
    assign unused_rdata  = ^bus.lcd_data_i;
    assign bus.lcd_rd    = 1'b1;
    assign bus.rsp_valid = 1'b0;
    assign bus.rsp_rdata = '0;
`endif

    assign bus.req_ready  = ready_q;
    assign bus.busy       = busy_q;
    assign bus.lcd_nrst   = nrst_q;
    assign bus.lcd_csel   = csel_q;
    assign bus.lcd_rs     = lrs_q;
    assign bus.lcd_wr     = wr_q;
    assign bus.lcd_data_o = dout_q;
    assign bus.lcd_data_z = {16{z_q}};
endmodule

// File: tb/tb_lcd_bus_seq.sv
// tb_lcd_bus_seq: table-driven transactions, read scoreboard, reset cases.
// Read expectations follow LCD_BUS_SEQ_READ_EN.
module tb_lcd_bus_seq;
    logic clk;
    logic resetn;
    lcd_bus_seq_if bus();

    lcd_bus_seq dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LCD_BUS_SEQ_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    typedef struct {
        logic        rs;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] din;
        logic [15:0] exp_rdata;
    } vec_t;

    int n_chk;
    int n_fail;
    logic [15:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Read scoreboard: every rsp_valid pulse pops one expected word.
    always @(negedge clk) begin
        if (resetn && bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got %h expected none",
                         bus.rsp_rdata);
            end else begin
                chk("rsp_rdata", {16'h0, bus.rsp_rdata},
                    {16'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_nrst", {31'h0, bus.lcd_nrst}, 0);
        chk("rst_csel", {31'h0, bus.lcd_csel}, 1);
        chk("rst_rs", {31'h0, bus.lcd_rs}, 1);
        chk("rst_wr", {31'h0, bus.lcd_wr}, 1);
        chk("rst_rd", {31'h0, bus.lcd_rd}, 1);
        chk("rst_dout", {16'h0, bus.lcd_data_o}, 0);
        chk("rst_z", {16'h0, bus.lcd_data_z}, 32'hFFFF);
        chk("rst_ready", {31'h0, bus.req_ready}, 0);
        chk("rst_rspv", {31'h0, bus.rsp_valid}, 0);
        chk("rst_rdata", {16'h0, bus.rsp_rdata}, 0);
        chk("rst_busy", {31'h0, bus.busy}, 1);
    endtask

    // Release reset at a falling edge; cycle j follows the j-th rising edge.
    task automatic run_reset_seq();
        @(negedge clk);
        resetn = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            chk("seq_nrst", {31'h0, bus.lcd_nrst}, {31'h0, j >= 16});
            chk("seq_ready", {31'h0, bus.req_ready}, {31'h0, j >= 48});
            chk("seq_busy", {31'h0, bus.busy}, {31'h0, j < 48});
            chk("seq_csel", {31'h0, bus.lcd_csel}, 1);
            chk("seq_wrrd", {30'h0, bus.lcd_wr, bus.lcd_rd}, 3);
            chk("seq_z", {16'h0, bus.lcd_data_z}, 32'hFFFF);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", {31'h0, bus.req_ready}, 1);
    endtask

    task automatic run_txn(input vec_t v);
        bit act;
        logic [15:0] junk;
        junk = 16'hDEAD;
        act  = v.we || RD_EN;
        wait_ready();
        bus.lcd_data_i = junk;
        bus.req_valid  = 1'b1;
        bus.req_rs     = v.rs;
        bus.req_we     = v.we;
        bus.req_wdata  = v.wdata;
        if (!v.we && RD_EN) sb_q.push_back(v.din);
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_valid = 1'b0;
                bus.req_wdata = 16'h5A5A;
                bus.req_rs    = ~v.rs;
            end
            chk("csel", {31'h0, bus.lcd_csel},
                {31'h0, !(act && k <= 8)});
            chk("wr", {31'h0, bus.lcd_wr},
                {31'h0, !(v.we && k >= 3 && k <= 6)});
            chk("rd", {31'h0, bus.lcd_rd},
                {31'h0, !(!v.we && RD_EN && k >= 3 && k <= 6)});
            chk("z", {16'h0, bus.lcd_data_z},
                (v.we && k <= 8) ? 32'h0 : 32'hFFFF);
            chk("ready", {31'h0, bus.req_ready},
                {31'h0, !act || k == 9});
            chk("busy", {31'h0, bus.busy}, {31'h0, act && k <= 8});
            chk("rspv", {31'h0, bus.rsp_valid},
                {31'h0, !v.we && RD_EN && k == 9});
            if (act && k <= 8)
                chk("rs", {31'h0, bus.lcd_rs}, {31'h0, v.rs});
            if (v.we && k <= 8)
                chk("dout", {16'h0, bus.lcd_data_o}, {16'h0, v.wdata});
            if (k == 2) bus.lcd_data_i = v.din;
            if (k == 7) bus.lcd_data_i = junk;
        end
        @(negedge clk);
        chk("rdata_hold", {16'h0, bus.rsp_rdata}, {16'h0, v.exp_rdata});
    endtask

    vec_t tbl[6];
    logic [15:0] rd_hold;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        resetn = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_rs     = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_wdata  = 16'h0;
        bus.lcd_data_i = 16'h0;

        rd_hold = RD_EN ? 16'h9341 : 16'h0;
        tbl[0] = '{1'b0, 1'b1, 16'h002C, 16'h0000, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'h0000, 16'h9341, rd_hold};
        tbl[2] = '{1'b1, 1'b1, 16'hA5A5, 16'h0000, rd_hold};
        tbl[3] = '{1'b1, 1'b1, 16'hFFFF, 16'h1234, rd_hold};
        rd_hold = RD_EN ? 16'h0F0F : 16'h0;
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h0F0F, rd_hold};
        tbl[5] = '{1'b0, 1'b1, 16'h002C, 16'h0000, rd_hold};

        repeat (3) @(negedge clk);
        chk_reset_vals();
        run_reset_seq();

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Back-to-back writes with req_valid held high.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_wdata = 16'h1111;
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_wdata = 16'h2222;
            if (k == 10) bus.req_valid = 1'b0;
            chk("b2b_csel", {31'h0, bus.lcd_csel},
                {31'h0, (k == 9) || (k == 18)});
            chk("b2b_wr", {31'h0, bus.lcd_wr},
                {31'h0, !((k >= 3 && k <= 6) || (k >= 12 && k <= 15))});
            chk("b2b_wrrd", {31'h0, bus.lcd_wr | bus.lcd_rd}, 1);
            if (k <= 8)
                chk("b2b_d1", {16'h0, bus.lcd_data_o}, 32'h1111);
            if (k >= 10 && k <= 17)
                chk("b2b_d2", {16'h0, bus.lcd_data_o}, 32'h2222);
        end

        // Asynchronous reset in the middle of a write strobe.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_wdata = 16'hBEEF;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
        end
        chk("pre_rst_wr", {31'h0, bus.lcd_wr}, 0);
        resetn = 1'b0;
        #1;
        chk_reset_vals();
        run_reset_seq();
        run_txn(tbl[0]);

        chk("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/lcd_bus_seq.md
Name: lcd_bus_seq

Overview:
Sequencer for the 16-bit 8080-style parallel LCD bus (csel/rs/wr/rd/nrst plus a tri-stated data bus).
- Accepts single command/data write and read requests from the CPU-side LCD register block over valid/ready.
- Generates programmable setup, strobe and hold timing, and drives the data-bus tri-state enables.
- Performs the panel hardware-reset pulse after system reset.
- Sits between the LCD register block and the top-level data IOBUFs.

Parameters:
- SETUP_CYC, 2: cycles with csel low and rs/data valid before the strobe falls (min 1).
- STROBE_CYC, 4: cycles the wr/rd strobe is held low (min 1).
- HOLD_CYC, 2: cycles after the strobe rises with csel low and data still driven (min 1).
- RST_CYC, 16: cycles lcd_nrst is held low after reset release (min 1).
- RST_WAIT_CYC, 32: cycles after lcd_nrst rises before the first request is accepted (min 1).

Ports:
- clk  in  1  single clock.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising clk edge.
- req_rs  in  1  0 = command, 1 = data.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle read-data pulse.
- rsp_rdata  out  16  captured read data, held until the next read.
- busy  out  1  high whenever the state is not IDLE.
- lcd_nrst  out  1  panel reset, active-low.
- lcd_csel  out  1  chip select, active-low.
- lcd_rs  out  1  register select.
- lcd_wr  out  1  write strobe, active-low.
- lcd_rd  out  1  read strobe, active-low.
- lcd_data_o  out  16  bus output data.
- lcd_data_i  in  16  bus input data.
- lcd_data_z  out  16  per-bit tri-state; 1 = high-Z (IOBUF T); all bits always equal.

Behaviour:
- Reset values while resetn = 0, applied asynchronously, including mid-transaction:
  - lcd_nrst = 0, lcd_csel = 1, lcd_rs = 1, lcd_wr = 1, lcd_rd = 1
  - lcd_data_o = 0, lcd_data_z = 16'hFFFF
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 1
  - State = RST_LOW.
- All outputs are registered.
- One down-counter, width $clog2 of the largest parameter + 1, is loaded on each state entry. The state advances when the counter expires after exactly N cycles in that state.
- RST_LOW: lcd_nrst = 0 for RST_CYC cycles -> RST_WAIT.
- RST_WAIT: lcd_nrst = 1 for RST_WAIT_CYC cycles -> IDLE.
- IDLE:
  - req_ready = 1, busy = 0, lcd_csel = 1, lcd_data_z = FFFF.
  - lcd_rs keeps its last value.
  - On handshake (call that edge cycle 0): latch rs/we/wdata -> SETUP. req_ready drops in cycle 1.
- SETUP (SETUP_CYC cycles):
  - lcd_csel = 0, lcd_rs = latched rs.
  - Write: lcd_data_o = wdata, z = 0000. Read: z = FFFF.
- STROBE (STROBE_CYC cycles):
  - lcd_wr = 0 for a write, lcd_rd = 0 for a read.
  - Read: lcd_data_i is sampled into rsp_rdata on the final STROBE cycle.
- HOLD (HOLD_CYC cycles): strobes = 1; csel, rs and data as in SETUP -> IDLE.
- On IDLE entry:
  - lcd_csel = 1 and z = FFFF.
  - For a read, rsp_valid = 1 for exactly that one cycle.
- With defaults: SETUP = cycles 1–2, STROBE = 3–6, HOLD = 7–8, IDLE with req_ready = 1 at cycle 9.
- Back-to-back requests: there is always at least one IDLE cycle (csel high) between transactions. Maximum throughput is one transaction per SETUP+STROBE+HOLD+1 cycles.
- req_valid, req_rs, req_we and req_wdata are ignored outside IDLE.
- lcd_wr and lcd_rd are never low simultaneously.
- lcd_data_z = 0000 only when a write is in SETUP/STROBE/HOLD.

Optional Feature:
- Macro LCD_BUS_SEQ_READ_EN.
- Defined: read transactions behave as above.
- Undefined:
  - lcd_rd is tied to 1; rsp_valid and rsp_rdata are tied to 0.
  - A read request is still accepted, then discarded with no bus activity (csel stays 1); req_ready reasserts in cycle 1.
  - No read-capture logic is instantiated.

Test Plan:
- Release resetn, defaults -> lcd_nrst = 0 for 16 cycles, then 1; req_ready rises 32 cycles later (cycle 48 after release); csel/wr/rd stay 1 and z = FFFF throughout.
- Write req_rs = 0, wdata = 16'h002C at cycle 0 -> csel = 0 and rs = 0 in cycles 1–8; wr = 0 in cycles 3–6; data_o = 002C and z = 0000 in cycles 1–8; req_ready = 1 and z = FFFF at cycle 9.
- Read req_rs = 1, lcd_data_i = 16'h9341 during cycles 3–6 -> rd = 0 in cycles 3–6, z = FFFF throughout; rsp_valid = 1 only in cycle 9 with rsp_rdata = 9341; rdata holds 9341 afterwards.
- req_valid held high for two writes (0x1111, 0x2222) -> second accepted at the cycle-9 edge; csel = 1 in cycle 9; second wr pulse in cycles 12–15.
- resetn driven low during STROBE of a write -> immediately wr = 1, csel = 1, z = FFFF, nrst = 0; after release the full 16 + 32 reset sequence repeats.
- Build without LCD_BUS_SEQ_READ_EN, issue read -> no csel/rd activity, req_ready = 1 in cycle 1, rsp_valid never asserted; a following write behaves as in scenario 2.
